pixel_fetch: RTL
================

Name: pixel_fetch

Overview:
- OBI-manager read engine directly upstream of the CNN line buffer.
- On a start pulse it reads a packed 8-bit image from memory as 32-bit words.
- Words are buffered in a 2-entry FIFO, unpacked little-endian, and streamed one pixel per handshake on a valid/ready interface into the line buffer.
- Reports busy, a done pulse, and a sticky bus-error flag for the control/status registers.

Parameters:
- ADDR_WIDTH, 32, OBI address width.
- DATA_WIDTH, 8, pixel width; 32/DATA_WIDTH pixels per bus word (4 at default).
- CNT_WIDTH, 16, width of the pixel-count configuration.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle start; ignored while busy_o=1.
- base_addr_i  in  ADDR_WIDTH  word-aligned image base, sampled on accepted start.
- num_pixels_i  in  CNT_WIDTH  pixel count, sampled on accepted start.
- obi_req_o  out  1  OBI request.
- obi_addr_o  out  ADDR_WIDTH  OBI address; we=0 and be='1 are implied and not ported.
- obi_gnt_i  in  1  OBI grant.
- obi_rvalid_i  in  1  OBI read response valid.
- obi_rdata_i  in  32  OBI read data.
- obi_err_i  in  1  OBI response error, qualified by obi_rvalid_i.
- pixel_o  out  DATA_WIDTH  streamed pixel.
- pixel_valid_o  out  1  pixel valid.
- pixel_ready_i  in  1  downstream ready.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  single-cycle completion pulse, also fires on error abort.
- err_o  out  1  sticky bus error; cleared on the next accepted start.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; FIFO empty; byte_sel=0; counters 0.
  - All outputs 0: obi_req_o, obi_addr_o, pixel_o, pixel_valid_o, busy_o, done_o, err_o.
- Accepted start (start_i=1 in IDLE):
  - Latch addr=base_addr_i, pix_left=num_pixels_i, words_left=ceil(num_pixels_i/4); clear err_o.
  - If num_pixels_i=0: done_o pulses next cycle; stay IDLE; busy_o stays 0; no bus traffic.
  - Otherwise go to REQ.
- FSM states: IDLE, REQ, WAIT_R, DRAIN.
- REQ:
  - obi_req_o=1 only while (fifo_count < 2).
  - Once raised, obi_req_o and obi_addr_o are held stable until obi_gnt_i.
  - On req&gnt: addr+=4; words_left-=1; go to WAIT_R.
  - At most one transaction is outstanding.
- WAIT_R: on obi_rvalid_i:
  - obi_err_i=1: set err_o, flush FIFO, deassert pixel_valid_o, pulse done_o, go to IDLE.
  - Otherwise push obi_rdata_i into the FIFO, then go to DRAIN if words_left=0, else REQ.
  - FIFO push and pop in the same cycle is legal; count is unchanged.
- DRAIN: when pix_left reaches 0, pulse done_o and go to IDLE.
- Output stream:
  - pixel_valid_o = FIFO non-empty.
  - pixel_o = head[8*byte_sel +: 8], byte 0 first.
  - On valid&ready: pix_left-=1. If byte_sel=3 or pix_left=1, pop the head and reset byte_sel to 0; otherwise byte_sel+=1.
  - Unused bytes of the last partial word are discarded.
  - pixel_o and pixel_valid_o are held stable while pixel_ready_i=0.
- Latency:
  - Start at cycle t gives obi_req_o=1 at t+1.
  - rvalid at cycle r gives pixel_valid_o=1 at r+1 (FIFO registered).
- busy_o: high in REQ, WAIT_R and DRAIN.
- done_o: high for exactly the single cycle of the return to IDLE.
- Address arithmetic: wraps modulo 2^ADDR_WIDTH; no bounds check.
- Reset asserted mid-transfer: immediate return to reset state, including an outstanding transaction. A late rvalid arriving in IDLE is ignored.
- Backpressure: pixel_ready_i=0 holds the FIFO. When the FIFO is full, obi_req_o stays low, so no data is ever lost or overwritten.

Test Plan:
- Basic: base=0x1A100000, n=8, memory words 0x04030201, 0x08070605, always-grant with 1-cycle rvalid, ready=1 -> pixels 1..8 in order; exactly 2 requests at 0x1A100000 and 0x1A100004; one done_o pulse; err_o=0.
- Partial word: n=5 -> 2 requests; pixels 1..5 output; bytes 6..8 dropped; done_o after the 5th handshake.
- Backpressure: n=16, pixel_ready_i held 0 after the first word arrives -> after 2 words fetched obi_req_o stays 0; pixel_o=1 held stable; on release all 16 pixels stream out correctly.
- Grant stall: obi_gnt_i low for 5 cycles -> obi_req_o and obi_addr_o stay constant for all 5 cycles; a single transaction is issued.
- Error: obi_err_i=1 on the 2nd response (n=12) -> err_o=1, done_o pulses, no further requests, FIFO flushed; next start clears err_o.
- Edge cases, checked in turn:
  - n=0 -> done_o pulses with no requests.
  - start_i while busy -> ignored.
  - rst_i pulsed mid-transfer -> all outputs return to 0.

Source files
------------

// File: rtl/pixel_fetch.sv
// pixel_fetch: OBI read engine feeding the CNN line buffer.
// Words land in a 2-entry FIFO and are streamed as pixels, byte 0 first.
module pixel_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_pixels_i,
  output logic                  obi_req_o,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  input  logic                  obi_gnt_i,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i,
  input  logic                  obi_err_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);
  localparam int PPW  = 32 / DATA_WIDTH;
  localparam int SELW = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [SELW-1:0] SEL_LAST = SELW'(PPW - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DRAIN} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  pix_left_q;
  logic [CNT_WIDTH-1:0]  words_left_q;
  logic [SELW-1:0]       sel_q;
  logic [31:0]           fifo_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cnt_d;
  logic                  done_q;
  logic                  err_q;

  logic [31:0]           head;
  logic [CNT_WIDTH-1:0]  words_init;
  logic                  fire;
  logic                  pop;
  logic                  push;
  logic                  last_pix;

  assign head       = fifo_q[rd_ptr_q];
  assign words_init = (num_pixels_i / CNT_WIDTH'(PPW))
                    + CNT_WIDTH'((num_pixels_i % CNT_WIDTH'(PPW)) != '0);

  assign pixel_valid_o = (cnt_q != 2'd0);
  assign pixel_o       = pixel_valid_o ?
                         head[DATA_WIDTH*int'(sel_q) +: DATA_WIDTH] : '0;
  assign obi_req_o     = (state_q == REQ) && (cnt_q < 2'd2);
  assign obi_addr_o    = addr_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign err_o         = err_q;

  assign fire     = pixel_valid_o && pixel_ready_i;
  assign last_pix = (pix_left_q == CNT_WIDTH'(1));
  // The last word may be partial: pop it once the final pixel leaves.
  assign pop      = fire && ((sel_q == SEL_LAST) || last_pix);
  assign push     = (state_q == WAIT_R) && obi_rvalid_i && !obi_err_i;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pix_left_q   <= '0;
      words_left_q <= '0;
      sel_q        <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cnt_q        <= 2'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      if (fire) begin
        pix_left_q <= pix_left_q - 1'b1;
        sel_q      <= pop ? '0 : sel_q + 1'b1;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= obi_rdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q       <= base_addr_i;
            pix_left_q   <= num_pixels_i;
            words_left_q <= words_init;
            err_q        <= 1'b0;
            if (num_pixels_i == '0) done_q  <= 1'b1;
            else                    state_q <= REQ;
          end
        end
        REQ: begin
          if (obi_req_o && obi_gnt_i) begin
            addr_q       <= addr_q + ADDR_WIDTH'(32'd4);
            words_left_q <= words_left_q - 1'b1;
            state_q      <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (obi_rvalid_i) begin
            if (obi_err_i) begin
              err_q    <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= IDLE;
              cnt_q    <= 2'd0;
              wr_ptr_q <= 1'b0;
              rd_ptr_q <= 1'b0;
              sel_q    <= '0;
            end else if (words_left_q == '0) begin
              state_q <= DRAIN;
            end else begin
              state_q <= REQ;
            end
          end
        end
        DRAIN: begin
          if (fire && last_pix) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
